ifmap_window_spad: RTL and testbench

- Next-generation ifmap scratchpad for the PE. It holds a sliding window of input-feature-map values for the convolution row.
- A circular buffer with head/tail pointers replaces the physical shift register, so a slide moves pointers instead of the data array.
- Adds: programmable stride per shift, shift and write in the same cycle, relative read addressing, a registered read-valid, an occupancy count and a sticky error flag.

---
 rtl/pe_spad_pkg.sv | 41 ++++
 rtl/spad_ring_ptr.sv | 48 ++++
 rtl/ifmap_window_spad.sv | 198 +++++++++++++++++++
 tb/tb_ifmap_window_spad.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_spad_pkg.sv
// -----------------------------------------------------------------------------
// pe_spad_pkg
//   Constants, types and helpers shared by the PE scratchpads
//   (ifmap, filter, psum).
//
//   SPAD_*        default sizing for the PE spads
//   SPAD_CALC_W   width of the pointer arithmetic scratch values. It is wide
//                 enough that ptr + offset never overflows before the wrap.
//   spad_err_e    cause of the sticky error. It is kept visible in the hierarchy
//                 for debug.
//   wrap_add      a + b, minus depth if the sum is at least depth. The caller
//                 must keep the sum below 2*depth.
// -----------------------------------------------------------------------------
package pe_spad_pkg;

  localparam int unsigned SPAD_MEM_DEPTH  = 12;
  localparam int unsigned SPAD_DATA_WIDTH = 16;
  localparam int unsigned SPAD_MAX_STRIDE = 4;
  localparam int unsigned SPAD_CALC_W     = 8;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVF   = 2'd1,
    ERR_UDF   = 2'd2,
    ERR_RANGE = 2'd3
  } spad_err_e;

  function automatic logic [SPAD_CALC_W-1:0] wrap_add(
    input logic [SPAD_CALC_W-1:0] a,
    input logic [SPAD_CALC_W-1:0] b,
    input logic [SPAD_CALC_W-1:0] depth
  );
    logic [SPAD_CALC_W-1:0] sum;
    sum = a + b;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage

// File: rtl/spad_ring_ptr.sv
// -----------------------------------------------------------------------------
// spad_ring_ptr
//   Circular-buffer pointer. On an enabled edge it advances by a programmable
//   increment, wrapped modulo depth. Updates happen on the negedge of clk,
//   the same edge as the PE spads. Reset is synchronous and active-high.
//
//   clk       PE clock (negedge active)
//   reset     synchronous active-high reset; the pointer returns to 0
//   adv_en_i  advance enable
//   inc_i     increment, at most depth_i
//   depth_i   ring size (effective depth), at least 1
//   ptr_o     current pointer, always below depth_i
// -----------------------------------------------------------------------------
import pe_spad_pkg::*;

module spad_ring_ptr #(
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_en_i,
  input  logic [PTR_W-1:0] inc_i,
  input  logic [PTR_W-1:0] depth_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_en_i) begin
      ptr_d = PTR_W'(wrap_add(SPAD_CALC_W'(ptr_q), SPAD_CALC_W'(inc_i),
                              SPAD_CALC_W'(depth_i)));
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ifmap_window_spad.sv
// -----------------------------------------------------------------------------
// ifmap_window_spad
//   Ifmap scratchpad for the PE. It holds the sliding convolution window in a
//   circular buffer. A slide moves the head pointer; the stored data does not
//   move. All state updates on the negedge of clk. Reset is synchronous and
//   active-high.
//
//   Optional build macro: IFMAP_ZERO_SKIP_EN. When defined, it adds the
//   registered dout_zero output, which flags an all-zero read value.
//
//   Ports
//     clk         PE clock (negedge active)
//     reset       synchronous active-high reset
//     spad_depth  active capacity. 0 or a value above MEM_DEPTH selects
//                 MEM_DEPTH. Change it only while the spad is empty.
//     stride      number of entries discarded per shift
//     shift       slide the window by min(stride, count)
//     w_en / din  write request and write data
//     w_ready     room for a write (!full)
//     r_en        read request
//     r_addr      read offset from the oldest entry
//     dout        registered read data (0 for an out-of-range read)
//     r_valid     high for the cycle after an accepted r_en
//     count       number of valid entries
//     full        count == effective depth
//     empty       count == 0
//     err         sticky: overflow, underflow or out-of-range read
//     dout_zero   (IFMAP_ZERO_SKIP_EN only) read value is all-zero
// -----------------------------------------------------------------------------
import pe_spad_pkg::*;

module ifmap_window_spad #(
  parameter int unsigned MEM_DEPTH    = SPAD_MEM_DEPTH,
  parameter int unsigned DATA_WIDTH   = SPAD_DATA_WIDTH,
  parameter int unsigned MAX_STRIDE   = SPAD_MAX_STRIDE,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int unsigned CNT_WIDTH    = $clog2(MEM_DEPTH + 1),
  parameter int unsigned STRIDE_WIDTH = $clog2(MAX_STRIDE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_WIDTH-1:0]    spad_depth,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic                    shift,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    w_ready,
  input  logic                    r_en,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    r_valid,
  output logic [CNT_WIDTH-1:0]    count,
  output logic                    full,
  output logic                    empty,
`ifdef IFMAP_ZERO_SKIP_EN
  output logic                    dout_zero,
`endif
  output logic                    err
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [CNT_WIDTH-1:0]  eff_depth;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  head, tail;
  logic [CNT_WIDTH-1:0]  disc;
  logic                  full_int;
  logic                  wr_acc;
  logic                  ovf, udf, rd_oob;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  r_valid_q, r_valid_d;
  logic                  err_q, err_d;
  spad_err_e             err_cause;

  always_comb begin
    eff_depth = CNT_WIDTH'(MEM_DEPTH);
    if ((spad_depth != '0) && (spad_depth <= CNT_WIDTH'(MEM_DEPTH))) begin
      eff_depth = spad_depth;
    end
  end

  assign full_int = (count_q == eff_depth);
  assign full     = full_int;
  assign empty    = (count_q == '0);
  assign w_ready  = !full_int;
  assign count    = count_q;

  // Full is taken from the pre-edge count. A shift on the same edge does not
  // make room for the write.
  assign wr_acc = w_en && !full_int;
  assign ovf    = w_en && full_int;
  assign udf    = shift && (SPAD_CALC_W'(stride) > SPAD_CALC_W'(count_q));
  assign rd_oob = r_en && (SPAD_CALC_W'(r_addr) >= SPAD_CALC_W'(count_q));

  always_comb begin
    disc = '0;
    if (shift) begin
      disc = udf ? count_q : CNT_WIDTH'(stride);
    end
  end

  // disc <= count_q, so the subtraction never wraps below zero.
  assign count_d = count_q - disc + CNT_WIDTH'(wr_acc);

  spad_ring_ptr #(.PTR_W(CNT_WIDTH)) u_head (
    .clk      (clk),
    .reset    (reset),
    .adv_en_i (shift),
    .inc_i    (disc),
    .depth_i  (eff_depth),
    .ptr_o    (head)
  );

  spad_ring_ptr #(.PTR_W(CNT_WIDTH)) u_tail (
    .clk      (clk),
    .reset    (reset),
    .adv_en_i (wr_acc),
    .inc_i    (CNT_WIDTH'(1)),
    .depth_i  (eff_depth),
    .ptr_o    (tail)
  );

  // Only in-range reads use the index. For those, head + r_addr < 2*eff_depth,
  // so one wrap is enough.
  assign rd_idx  = ADDR_WIDTH'(wrap_add(SPAD_CALC_W'(head), SPAD_CALC_W'(r_addr),
                                        SPAD_CALC_W'(eff_depth)));
  assign rd_word = rd_oob ? '0 : mem_q[rd_idx];

  always_comb begin
    err_cause = ERR_NONE;
    if (ovf) begin
      err_cause = ERR_OVF;
    end else if (udf) begin
      err_cause = ERR_UDF;
    end else if (rd_oob) begin
      err_cause = ERR_RANGE;
    end
  end

  always_comb begin
    dout_d    = dout_q;
    r_valid_d = 1'b0;
    if (r_en) begin
      dout_d    = rd_word;
      r_valid_d = 1'b1;
    end
    err_d = err_q | (err_cause != ERR_NONE);
  end

  // Storage is never cleared. An entry only becomes visible after it is written.
  always_ff @(negedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[ADDR_WIDTH'(tail)] <= din;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      count_q   <= '0;
      dout_q    <= '0;
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      dout_q    <= dout_d;
      r_valid_q <= r_valid_d;
      err_q     <= err_d;
    end
  end

  assign dout    = dout_q;
  assign r_valid = r_valid_q;
  assign err     = err_q;

`ifdef IFMAP_ZERO_SKIP_EN
  logic dout_zero_q, dout_zero_d;

  always_comb begin
    dout_zero_d = dout_zero_q;
    if (r_en) begin
      dout_zero_d = (rd_word == '0);
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      dout_zero_q <= 1'b0;
    end else begin
      dout_zero_q <= dout_zero_d;
    end
  end

  assign dout_zero = dout_zero_q;
`endif

endmodule

// File: tb/tb_ifmap_window_spad.sv
module tb_ifmap_window_spad;

  logic        clk = 1'b1;
  logic        reset;
  logic [3:0]  spad_depth;
  logic [2:0]  stride;
  logic        shift;
  logic        w_en;
  logic [15:0] din;
  logic        w_ready;
  logic        r_en;
  logic [3:0]  r_addr;
  logic [15:0] dout;
  logic        r_valid;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        err;
`ifdef IFMAP_ZERO_SKIP_EN
  logic        dout_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] q [$];

  always #5 clk = ~clk;

  ifmap_window_spad dut (
    .clk        (clk),
    .reset      (reset),
    .spad_depth (spad_depth),
    .stride     (stride),
    .shift      (shift),
    .w_en       (w_en),
    .din        (din),
    .w_ready    (w_ready),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .dout       (dout),
    .r_valid    (r_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
`ifdef IFMAP_ZERO_SKIP_EN
    .dout_zero  (dout_zero),
`endif
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge; the DUT acts on the following negedge; outputs
  // are checked at the next posedge.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    w_en = 1'b1; din = d;
    cyc();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    r_en = 1'b1; r_addr = a;
    cyc();
    r_en = 1'b0;
  endtask

  task automatic shift_by(input logic [2:0] s);
    stride = s; shift = 1'b1;
    cyc();
    shift = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; spad_depth = 4'd3; stride = 3'd1; shift = 1'b0;
    w_en = 1'b0; din = '0; r_en = 1'b0; r_addr = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state and overflow at depth 3
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_empty",   32'(empty), 32'd1);
    chk("rst_wready",  32'(w_ready), 32'd1);
    chk("rst_dout",    32'(dout), 32'd0);
    chk("rst_rvalid",  32'(r_valid), 32'd0);
    chk("rst_err",     32'(err), 32'd0);
    wr(16'h11); wr(16'h22); wr(16'h33);
    chk("fill_count",  32'(count), 32'd3);
    chk("fill_full",   32'(full), 32'd1);
    chk("fill_wready", 32'(w_ready), 32'd0);
    chk("fill_err",    32'(err), 32'd0);
    wr(16'h44);
    chk("ovf_count",   32'(count), 32'd3);
    chk("ovf_err",     32'(err), 32'd1);
    rd(4'd0);
    chk("ovf_rd0",     32'(dout), 32'h11);
    chk("ovf_rv",      32'(r_valid), 32'd1);
    cyc();
    chk("idle_rv",     32'(r_valid), 32'd0);
    chk("idle_hold",   32'(dout), 32'h11);
    rd(4'd2);
    chk("ovf_rd2",     32'(dout), 32'h33);

    // When full, a shift on the same edge does not make room for the write
    do_reset();
    chk("rst2_err",    32'(err), 32'd0);
    wr(16'h11); wr(16'h22); wr(16'h33);
    stride = 3'd1; shift = 1'b1; w_en = 1'b1; din = 16'h44;
    cyc();
    shift = 1'b0; w_en = 1'b0;
    chk("fsw_count",   32'(count), 32'd2);
    chk("fsw_err",     32'(err), 32'd1);
    rd(4'd0); chk("fsw_rd0", 32'(dout), 32'h22);
    rd(4'd1); chk("fsw_rd1", 32'(dout), 32'h33);

    // Shift and write on the same edge, with room, at depth 4
    reset = 1'b1; spad_depth = 4'd4;
    cyc();
    reset = 1'b0;
    wr(16'h11); wr(16'h22); wr(16'h33);
    stride = 3'd1; shift = 1'b1; w_en = 1'b1; din = 16'h44;
    cyc();
    shift = 1'b0; w_en = 1'b0;
    chk("sw_count",    32'(count), 32'd3);
    rd(4'd0); chk("sw_rd0", 32'(dout), 32'h22); chk("sw_rv0", 32'(r_valid), 32'd1);
    rd(4'd1); chk("sw_rd1", 32'(dout), 32'h33); chk("sw_rv1", 32'(r_valid), 32'd1);
    rd(4'd2); chk("sw_rd2", 32'(dout), 32'h44); chk("sw_rv2", 32'(r_valid), 32'd1);
    chk("sw_err",      32'(err), 32'd0);
    rd(4'd3);
    chk("oob_dout",    32'(dout), 32'd0);
    chk("oob_rv",      32'(r_valid), 32'd1);
    chk("oob_err",     32'(err), 32'd1);

    // Stride 2 at depth 5 over 10 shifts, so the pointers wrap
    reset = 1'b1; spad_depth = 4'd5;
    cyc();
    reset = 1'b0;
    q.delete();
    for (int k = 0; k < 5; k++) begin
      wr(16'h100 + 16'(k));
      q.push_back(16'h100 + 16'(k));
    end
    for (int i = 0; i < 10; i++) begin
      shift_by(3'd2);
      void'(q.pop_front());
      void'(q.pop_front());
      chk("wrap_cnt3", 32'(count), 32'd3);
      wr(16'h200 + 16'(2*i));
      q.push_back(16'h200 + 16'(2*i));
      wr(16'h201 + 16'(2*i));
      q.push_back(16'h201 + 16'(2*i));
      rd(4'd0);
      chk("wrap_oldest", 32'(dout), 32'(q[0]));
      chk("wrap_cnt5",   32'(count), 32'd5);
    end
    rd(4'd4);
    chk("wrap_newest", 32'(dout), 32'(q[4]));
    chk("wrap_err",    32'(err), 32'd0);

    // Underflow: stride larger than count
    do_reset();
    wr(16'h77);
    rd(4'd0);
    chk("udf_pre_rd",  32'(dout), 32'h77);
    shift_by(3'd3);
    chk("udf_count",   32'(count), 32'd0);
    chk("udf_empty",   32'(empty), 32'd1);
    chk("udf_err",     32'(err), 32'd1);
    rd(4'd0);
    chk("udf_rd_dout", 32'(dout), 32'd0);
    chk("udf_rd_rv",   32'(r_valid), 32'd1);

    // Reset in the middle of operation, with a write and a read on the same edge
    do_reset();
    chk("rst5_err",    32'(err), 32'd0);
    wr(16'hA1); wr(16'hA2);
    rd(4'd3);
    chk("pre_oob_err", 32'(err), 32'd1);
    rd(4'd0);
    chk("pre_rd",      32'(dout), 32'hA1);
    reset = 1'b1; w_en = 1'b1; din = 16'hBB; r_en = 1'b1; r_addr = 4'd0;
    cyc();
    reset = 1'b0; w_en = 1'b0; r_en = 1'b0;
    chk("mid_count",   32'(count), 32'd0);
    chk("mid_empty",   32'(empty), 32'd1);
    chk("mid_dout",    32'(dout), 32'd0);
    chk("mid_rv",      32'(r_valid), 32'd0);
    chk("mid_err",     32'(err), 32'd0);
    wr(16'hC1);
    chk("post_count",  32'(count), 32'd1);
    rd(4'd0);
    chk("post_rd",     32'(dout), 32'hC1);

`ifdef IFMAP_ZERO_SKIP_EN
    do_reset();
    chk("zs_rst",      32'(dout_zero), 32'd0);
    wr(16'h0000); wr(16'h0005);
    rd(4'd0);
    chk("zs_zero",     32'(dout_zero), 32'd1);
    rd(4'd1);
    chk("zs_nonzero",  32'(dout_zero), 32'd0);
    chk("zs_dout",     32'(dout), 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
